// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front end.
// Provides the FSM state enum, default word widths and the command codes
// the RAM decodes from rx_data[9:8].
package spi_pkg;

    localparam int RX_W_DEF = 10;
    localparam int TX_W_DEF = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

endpackage

// File: rtl/spi_slave.sv
// spi_slave: deserialises MOSI frames into command words and serialises RAM read bytes on MISO.
// Ports:
//   clk      SPI clock, everything samples on posedge
//   rst      synchronous active-high reset
//   SS_n     active-low slave select framing each transaction
//   MOSI     serial data in, MSB first
//   tx_data  read byte from RAM
//   tx_valid tx_data valid strobe from RAM
//   MISO     registered serial data out, MSB first
//   rx_data  registered command word {cmd[1:0], payload[7:0]}
//   rx_valid one-cycle strobe, rx_data complete
module spi_slave
    import spi_pkg::*;
#(
    parameter int RX_W = RX_W_DEF,
    parameter int TX_W = TX_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            SS_n,
    input  logic            MOSI,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid
);

    localparam int CNT_W = $clog2(RX_W);
    localparam int TXC_W = $clog2(TX_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RX_W - 2);
    localparam logic [TXC_W-1:0] TX_LAST = TXC_W'(TX_W - 1);

    spi_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [RX_W-2:0] sr_q;
    logic [RX_W-1:0] rx_data_q;
    logic rx_valid_q;
    logic done_q;
    logic rd_addr_seen_q;
    logic tx_loaded_q;
    logic [TX_W-1:0] tx_sr_q;
    logic [TXC_W-1:0] tx_cnt_q;
    logic miso_q;
    logic in_frame, shift_en, last_bit, tx_load, abort;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Command bit 9 picks write vs read; a read goes to READ_DATA only once an address frame has been seen.
    always_comb begin
        state_d = state_q == IDLE ? (SS_n ? IDLE : CHK_CMD) :
                  SS_n ? IDLE :
                  state_q == CHK_CMD ? (MOSI == CMD_RD_ADDR[1] ? (rd_addr_seen_q ? READ_DATA : READ_ADD) : WRITE) :
                  state_q;
    end

    // done_q blocks any further capture once the word is complete while SS_n stays low.
    always_comb begin
        in_frame = state_q == WRITE || state_q == READ_ADD || state_q == READ_DATA;
        abort    = state_q != IDLE && SS_n;
        shift_en = in_frame && !SS_n && !done_q;
        last_bit = shift_en && cnt_q == LAST;
        tx_load  = state_q == READ_DATA && !SS_n && done_q && tx_valid && !tx_loaded_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            sr_q           <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            done_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_loaded_q    <= 1'b0;
            tx_sr_q        <= '0;
            tx_cnt_q       <= '0;
            miso_q         <= 1'b0;
        end else if (abort) begin
            cnt_q       <= '0;
            rx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            tx_loaded_q <= 1'b0;
            tx_cnt_q    <= '0;
            miso_q      <= 1'b0;
        end else begin
            rx_valid_q <= last_bit;
            if (state_q == CHK_CMD) sr_q <= {{(RX_W-2){1'b0}}, MOSI};
            else if (shift_en) sr_q <= {sr_q[RX_W-3:0], MOSI};
            if (shift_en && !last_bit) cnt_q <= cnt_q + 1'b1;
            if (last_bit) begin
                rx_data_q      <= {sr_q, MOSI};
                done_q         <= 1'b1;
                rd_addr_seen_q <= state_q == READ_ADD ? 1'b1 : state_q == READ_DATA ? 1'b0 : rd_addr_seen_q;
            end
            // MSB goes straight to MISO on the load edge; the remaining bits follow from tx_sr_q.
            if (tx_load) begin
                miso_q      <= tx_data[TX_W-1];
                tx_sr_q     <= {tx_data[TX_W-2:0], 1'b0};
                tx_cnt_q    <= TX_LAST;
                tx_loaded_q <= 1'b1;
            end else if (tx_cnt_q != '0) begin
                miso_q   <= tx_sr_q[TX_W-1];
                tx_sr_q  <= {tx_sr_q[TX_W-2:0], 1'b0};
                tx_cnt_q <= tx_cnt_q - 1'b1;
            end else begin
                miso_q <= 1'b0;
            end
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized frame-level bench for spi_slave with a behavioural RAM and protocol model.
module tb_spi_slave;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst, ss_n, mosi, tx_valid, miso, rx_valid;
    logic [7:0] tx_data;
    logic [9:0] rx_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [256];
    logic [7:0] wr_addr, rd_addr;
    logic rd_seen;
    logic [9:0] exp_rx;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .MISO(miso), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply the effect of a completed word to the RAM model and read-address tracking.
    task automatic model_done(input logic [9:0] w);
        exp_rx = w;
        if (w[9]) rd_seen = !rd_seen;
        case (w[9:8])
            CMD_WR_ADDR: wr_addr = w[7:0];
            CMD_WR_DATA: mem[wr_addr] = w[7:0];
            CMD_RD_ADDR: rd_addr = w[7:0];
            default: ;
        endcase
    endtask

    // One SS_n-low transaction. abort_at: edge (1..10) where SS_n rises early, 0 for a full word.
    // last_k: last edge index held low after the word. rst_at: edge where rst is asserted, 0 for none.
    task automatic frame(input logic [9:0] w, input int abort_at, input int last_k, input int rst_at);
        logic rd;
        logic [7:0] b;
        rd = w[9] && rd_seen;
        b = mem[rd_addr];
        ss_n = 1'b0;
        mosi = 1'($urandom);
        tx_valid = 1'($urandom);
        tx_data = 8'($urandom);
        step();
        chk("e0_rx_valid", rx_valid, 0);
        for (int k = 1; k <= 10; k++) begin
            if (k == abort_at) begin
                ss_n = 1'b1;
                step();
                chk("abort_rx_valid", rx_valid, 0);
                chk("abort_rx_data", rx_data, exp_rx);
                chk("abort_miso", miso, 0);
                return;
            end
            mosi = w[10-k];
            tx_valid = 1'($urandom);
            tx_data = 8'($urandom);
            step();
            chk("bit_rx_valid", rx_valid, k == 10);
            chk("bit_rx_data", rx_data, k == 10 ? w : exp_rx);
            chk("bit_miso", miso, 0);
        end
        model_done(w);
        for (int k = 11; k <= last_k; k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                step();
                chk("rst_miso", miso, 0);
                chk("rst_rx_valid", rx_valid, 0);
                chk("rst_rx_data", rx_data, 0);
                rst = 1'b0;
                ss_n = 1'b1;
                rd_seen = 1'b0;
                exp_rx = '0;
                step();
                chk("post_rst_miso", miso, 0);
                chk("post_rst_rx_valid", rx_valid, 0);
                return;
            end
            mosi = 1'($urandom);
            if (rd) begin
                tx_valid = k == 12 ? 1'b1 : k == 11 ? 1'b0 : 1'($urandom);
                tx_data = k == 12 ? b : 8'($urandom);
            end else begin
                tx_valid = 1'($urandom);
                tx_data = 8'($urandom);
            end
            step();
            chk("tail_rx_valid", rx_valid, 0);
            chk("tail_rx_data", rx_data, exp_rx);
            chk("miso", miso, (rd && k >= 12 && k <= 19) ? b[19-k] : 1'b0);
        end
        ss_n = 1'b1;
        tx_valid = 1'($urandom);
        step();
        chk("end_rx_valid", rx_valid, 0);
        chk("end_rx_data", rx_data, exp_rx);
        chk("end_miso", miso, 0);
    endtask

    initial begin
        logic [1:0] cmd;
        logic [7:0] pl;
        rst = 1'b1;
        ss_n = 1'b0;
        mosi = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        rd_seen = 1'b0;
        exp_rx = '0;
        wr_addr = '0;
        rd_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        step();
        step();
        chk("reset_miso", miso, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);
        rst = 1'b0;
        ss_n = 1'b1;
        tx_valid = 1'b0;
        step();
        frame(10'h05A, 0, 11, 0);
        frame(10'h1C3, 0, 11, 0);
        frame(10'h25A, 0, 11, 0);
        frame(10'h300, 0, 20, 0);
        chk("read_back_c3", mem[8'h5A], 8'hC3);
        frame(10'h2AA, 6, 0, 0);
        frame(10'h0F0, 0, 12, 0);
        frame(10'h25A, 0, 11, 0);
        frame(10'h300, 0, 20, 15);
        frame(10'h211, 0, 11, 0);
        frame(10'h0AA, 0, 11, 11);
        frame(10'h3FF, 0, 22, 0);
        for (int i = 0; i < 60; i++) begin
            cmd = 2'($urandom);
            pl = cmd[0] ? 8'($urandom) : 8'($urandom_range(0, 7));
            frame({cmd, pl}, $urandom_range(0, 4) == 0 ? $urandom_range(1, 10) : 0, $urandom_range(11, 24), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
